// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port controller: arbitrates IF word fetch vs MEM byte/half/word access (MEM_CTRL_IF_PRIORITY_EN gives IF the tie).
// Latency from accept edge: read n+1 edges, write n edges, NOP 0; one IDLE + one DONE cycle between transactions.
// Requests are held until done; a pending request waits in IDLE, an IF read aborts when if_req_i drops.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
);

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;
    localparam logic [1:0] MEM_NOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic        owner_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  n;
    logic [2:0]  issue_idx;
    logic [2:0]  cap_idx;
    logic [1:0]  rd_pipe;

    logic        take_mem;
    logic        take_if;
    logic [31:0] issue_addr;
    logic        all_issued;
    logic        last_cap;

`ifdef MEM_CTRL_IF_PRIORITY_EN
    assign take_if  = if_req_i;
    assign take_mem = mem_req_i && !if_req_i;
`else
    assign take_mem = mem_req_i;
    assign take_if  = if_req_i && !mem_req_i;
`endif

    assign issue_addr = addr + {29'd0, issue_idx};
    assign all_issued = (issue_idx == n);
    assign last_cap   = (cap_idx == n - 3'd1);

    function automatic logic [2:0] sel_len(input logic [1:0] sel);
        case (sel)
            MEM_BYTE: sel_len = 3'd1;
            MEM_HALF: sel_len = 3'd2;
            MEM_WORD: sel_len = 3'd4;
            default:  sel_len = 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_mem   <= 1'b0;
            addr        <= 32'd0;
            wdata       <= 32'd0;
            n           <= 3'd0;
            issue_idx   <= 3'd0;
            cap_idx     <= 3'd0;
            rd_pipe     <= 2'b00;
            ram_a_o     <= 32'd0;
            ram_wr_o    <= 1'b0;
            ram_dout_o  <= 8'd0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
            if_data_o   <= 32'd0;
            mem_rdata_o <= 32'd0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    ram_a_o   <= 32'd0;
                    ram_wr_o  <= 1'b0;
                    issue_idx <= 3'd0;
                    cap_idx   <= 3'd0;
                    rd_pipe   <= 2'b00;
                    if (take_mem) begin
                        owner_mem   <= 1'b1;
                        addr        <= mem_addr_i;
                        wdata       <= mem_wdata_i;
                        n           <= sel_len(mem_sel_i);
                        mem_rdata_o <= 32'd0;
                        if (mem_sel_i == MEM_NOP) begin
                            state      <= DONE;
                            mem_done_o <= 1'b1;
                        end else begin
                            ram_a_o   <= mem_addr_i;
                            issue_idx <= 3'd1;
                            if (mem_we_i) begin
                                state      <= WRITE;
                                ram_wr_o   <= 1'b1;
                                ram_dout_o <= mem_wdata_i[7:0];
                            end else begin
                                state   <= READ;
                                rd_pipe <= 2'b01;
                            end
                        end
                    end else if (take_if) begin
                        owner_mem <= 1'b0;
                        addr      <= if_addr_i;
                        n         <= 3'd4;
                        if_data_o <= 32'd0;
                        ram_a_o   <= if_addr_i;
                        issue_idx <= 3'd1;
                        rd_pipe   <= 2'b01;
                        state     <= READ;
                    end
                end

                READ: begin
                    if (!owner_mem && !if_req_i) begin
                        // fetch withdrawn: stop issuing at once and drop partial data
                        state     <= IDLE;
                        ram_a_o   <= 32'd0;
                        rd_pipe   <= 2'b00;
                        issue_idx <= 3'd0;
                        cap_idx   <= 3'd0;
                    end else begin
                        if (!all_issued) begin
                            ram_a_o    <= issue_addr;
                            issue_idx  <= issue_idx + 3'd1;
                            rd_pipe[0] <= 1'b1;
                        end else begin
                            ram_a_o    <= 32'd0;
                            rd_pipe[0] <= 1'b0;
                        end
                        rd_pipe[1] <= rd_pipe[0];
                        // RAM returns each byte two edges after its address was loaded
                        if (rd_pipe[1]) begin
                            if (owner_mem) begin
                                mem_rdata_o[{cap_idx[1:0], 3'b000} +: 8] <= ram_din_i;
                            end else begin
                                if_data_o[{cap_idx[1:0], 3'b000} +: 8] <= ram_din_i;
                            end
                            cap_idx <= cap_idx + 3'd1;
                            if (last_cap) begin
                                state <= DONE;
                                if (owner_mem) begin
                                    mem_done_o <= 1'b1;
                                end else begin
                                    if_done_o <= 1'b1;
                                end
                            end
                        end
                    end
                end

                WRITE: begin
                    if (all_issued) begin
                        ram_wr_o   <= 1'b0;
                        ram_a_o    <= 32'd0;
                        ram_dout_o <= 8'd0;
                        state      <= DONE;
                        mem_done_o <= 1'b1;
                    end else begin
                        ram_a_o    <= issue_addr;
                        ram_dout_o <= wdata[{issue_idx[1:0], 3'b000} +: 8];
                        issue_idx  <= issue_idx + 3'd1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    ram_a_o  <= 32'd0;
                    ram_wr_o <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, hand-written corner sequences, randomized traffic against a byte-map model.
module tb_mem_ctrl;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;
    localparam logic [1:0] MEM_NOP  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
        .ram_a_o(ram_a), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din)
    );

    // Environment RAM (written by the DUT) and reference RAM (written by the model only)
    logic [7:0] env_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    logic [39:0] wlog [$];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction
    function automatic logic [7:0] env_get(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return dflt(a);
    endfunction
    function automatic logic [7:0] ref_get(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | ({24'd0, ref_get(a + 32'(i))} << (8 * i));
        return v;
    endfunction
    function automatic int len_of(input bit is_mem, input logic [1:0] sel);
        if (!is_mem) return 4;
        case (sel)
            MEM_BYTE: return 1;
            MEM_HALF: return 2;
            MEM_WORD: return 4;
            default:  return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_wr) begin
            env_mem[ram_a] = ram_dout;
            wlog.push_back({ram_a, ram_dout});
        end
        ram_din <= env_get(ram_a);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Runs one transaction from IDLE; bus, latency, data and write log all checked.
    task automatic run_txn(input string nm, input bit is_mem, input bit we, input logic [1:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_data, input bit chk_data);
        int n;
        int lat;
        int seq_err;
        int nwr;
        bit done;
        logic [31:0] got;
        logic [31:0] exp_a;
        logic [31:0] tmp;
        bit exp_wr;
        n = len_of(is_mem, sel);
        lat = -1;
        seq_err = 0;
        done = 1'b0;
        got = 32'd0;
        wlog.delete();
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 0; k <= 20 && !done; k++) begin
            @(negedge clk);
            exp_a = (k < n) ? addr + 32'(k) : 32'd0;
            exp_wr = is_mem && we && (k < n);
            if (ram_a !== exp_a || ram_wr !== exp_wr) seq_err++;
            if (exp_wr) begin
                tmp = wdata >> (8 * k);
                if (ram_dout !== tmp[7:0]) seq_err++;
            end
            if (is_mem ? if_done : mem_done) seq_err++;
            if (is_mem ? mem_done : if_done) begin
                done = 1'b1;
                lat = k;
                got = is_mem ? mem_rdata : if_data;
            end
        end
        mem_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        if (ram_a !== 32'd0 || ram_wr !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0) seq_err++;
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " bus"}, 32'(seq_err), 32'd0);
        if (chk_data) check({nm, " data"}, got, exp_data);
        nwr = (is_mem && we) ? n : 0;
        seq_err = (wlog.size() != nwr) ? 1 : 0;
        for (int i = 0; i < nwr && i < wlog.size(); i++) begin
            tmp = wdata >> (8 * i);
            if (wlog[i] !== {addr + 32'(i), tmp[7:0]}) seq_err++;
        end
        check({nm, " writes"}, 32'(seq_err), 32'd0);
        for (int i = 0; i < nwr; i++) begin
            tmp = wdata >> (8 * i);
            ref_mem[addr + 32'(i)] = tmp[7:0];
        end
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] data;
        bit          chk;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int t_mem;
        int t_if;
        int bad;
        logic [31:0] exp_if;

        vecs[0]  = '{1, 0, MEM_WORD, 32'h100,      32'h0,        5, 32'h12345678, 1};
        vecs[1]  = '{0, 0, MEM_WORD, 32'h100,      32'h0,        5, 32'h12345678, 1};
        vecs[2]  = '{1, 0, MEM_BYTE, 32'h102,      32'h0,        2, 32'h00000034, 1};
        vecs[3]  = '{1, 0, MEM_HALF, 32'h101,      32'h0,        3, 32'h00003456, 1};
        vecs[4]  = '{1, 1, MEM_HALF, 32'h200,      32'hAABBCCDD, 2, 32'h0,        0};
        vecs[5]  = '{1, 0, MEM_HALF, 32'h200,      32'h0,        3, 32'h0000CCDD, 1};
        vecs[6]  = '{1, 1, MEM_BYTE, 32'h210,      32'h12345699, 1, 32'h0,        0};
        vecs[7]  = '{1, 0, MEM_BYTE, 32'h210,      32'h0,        2, 32'h00000099, 1};
        vecs[8]  = '{1, 1, MEM_WORD, 32'h220,      32'hCAFEF00D, 4, 32'h0,        0};
        vecs[9]  = '{0, 0, MEM_WORD, 32'h220,      32'h0,        5, 32'hCAFEF00D, 1};
        vecs[10] = '{1, 0, MEM_HALF, 32'hFFFFFFFF, 32'h0,        3, 32'h000077EE, 1};
        vecs[11] = '{1, 0, MEM_NOP,  32'h104,      32'h0,        0, 32'h0,        1};
        vecs[12] = '{1, 1, MEM_NOP,  32'h108,      32'hFFFFFFFF, 0, 32'h0,        1};

        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
        mem_sel = MEM_BYTE; mem_addr = 32'd0; mem_wdata = 32'd0;
        preset(32'h100, 8'h78); preset(32'h101, 8'h56); preset(32'h102, 8'h34); preset(32'h103, 8'h12);
        preset(32'hFFFFFFFF, 8'hEE); preset(32'h0, 8'h77);
        repeat (3) @(negedge clk);
        check("reset ram_a", ram_a, 32'd0);
        check("reset ram_wr", {31'd0, ram_wr}, 32'd0);
        check("reset ram_dout", {24'd0, ram_dout}, 32'd0);
        check("reset if_done", {31'd0, if_done}, 32'd0);
        check("reset mem_done", {31'd0, mem_done}, 32'd0);
        check("reset if_data", if_data, 32'd0);
        check("reset mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].is_mem, vecs[i].we, vecs[i].sel, vecs[i].addr,
                    vecs[i].wdata, vecs[i].lat, vecs[i].data, vecs[i].chk);

        // Simultaneous requests in IDLE
        exp_if = model_rd(32'h200, 4);
        t_mem = 0; t_if = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_WORD; mem_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h200;
        for (int c = 1; c <= 40 && (t_mem == 0 || t_if == 0); c++) begin
            @(negedge clk);
            if (mem_done && t_mem == 0) begin
                t_mem = c; mem_req = 1'b0;
                check("tie mem data", mem_rdata, 32'h12345678);
            end
            if (if_done && t_if == 0) begin
                t_if = c; if_req = 1'b0;
                check("tie if data", if_data, exp_if);
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
`ifdef MEM_CTRL_IF_PRIORITY_EN
        check("tie if time", 32'(t_if), 32'd6);
        check("tie mem time", 32'(t_mem), 32'd13);
`else
        check("tie mem time", 32'(t_mem), 32'd6);
        check("tie if time", 32'(t_if), 32'd13);
`endif
        repeat (2) @(negedge clk);

        // Fetch aborted after E2 with a load waiting behind it
        bad = 0;
        if_req = 1'b1; if_addr = 32'h0;
        repeat (3) begin
            @(negedge clk);
            if (if_done) bad++;
        end
        if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_WORD; mem_addr = 32'h100;
        @(negedge clk);
        check("abort ram_a zero", ram_a, 32'd0);
        if (if_done) bad++;
        @(negedge clk);
        check("abort queued mem start", ram_a, 32'h100);
        t_mem = 0;
        for (int c = 1; c <= 20 && t_mem == 0; c++) begin
            @(negedge clk);
            if (if_done) bad++;
            if (mem_done) begin
                t_mem = c;
                check("abort mem data", mem_rdata, 32'h12345678);
            end
        end
        mem_req = 1'b0;
        check("abort mem latency", 32'(t_mem), 32'd5);
        check("abort no if_done", 32'(bad), 32'd0);
        @(negedge clk);

        // Reset at E1 of a word store
        bad = 0;
        wlog.delete();
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = MEM_WORD; mem_addr = 32'h300; mem_wdata = 32'h11223344;
        @(negedge clk);
        check("rstw first write", {31'd0, ram_wr}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstw ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rstw ram_a", ram_a, 32'd0);
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        repeat (6) begin
            if (mem_done || if_done) bad++;
            @(negedge clk);
        end
        check("rstw no done", 32'(bad), 32'd0);
        check("rstw write count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) check("rstw write byte", wlog[0][31:0], {24'h300, 8'h44});
        ref_mem[32'h300] = 8'h44;
        run_txn("rstw readback", 1, 0, MEM_WORD, 32'h300, 32'h0, 5, model_rd(32'h300, 4), 1);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            bit          r_mem;
            bit          r_we;
            logic [1:0]  r_sel;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;
            logic [31:0] bases [4];
            int          n;
            int          lat;
            bases[0] = 32'h100; bases[1] = 32'h200; bases[2] = 32'hFFFFFFF8; bases[3] = 32'h1000;
            r_mem = ($urandom_range(0, 3) != 0);
            r_we = r_mem && ($urandom_range(0, 1) != 0);
            r_sel = 2'($urandom_range(0, 3));
            r_addr = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15));
            r_wdata = $urandom;
            n = len_of(r_mem, r_sel);
            lat = (n == 0) ? 0 : (r_we ? n : n + 1);
            run_txn($sformatf("rnd%0d", t), r_mem, r_we, r_sel, r_addr, r_wdata, lat,
                    r_we ? 32'd0 : model_rd(r_addr, n), !r_we);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory controller directly downstream of the `mem` stage and the `if` stage. It owns the single 8-bit RAM/IO port and arbitrates between instruction fetch (always a word read) and data access (byte/half/word, read or write). It splits each request into sequential byte accesses and assembles read data little-endian. It returns a one-cycle done pulse to the requester.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req_i` in 1: fetch request; held until `if_done_o`, may drop early to abort.
- `if_addr_i` in 32: fetch byte address.
- `if_data_o` out 32: fetched word; valid in the `if_done_o` cycle.
- `if_done_o` out 1: one-cycle fetch completion pulse.
- `mem_req_i` in 1: data request; held until `mem_done_o`.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_sel_i` in 2: `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`/`MEM_NOP` from the shared defines.
- `mem_addr_i` in 32: data byte address.
- `mem_wdata_i` in 32: store data; low 1/2/4 bytes used.
- `mem_rdata_o` out 32: load data, zero-extended; the `mem` stage applies sign extension. Valid in the `mem_done_o` cycle.
- `mem_done_o` out 1: one-cycle data completion pulse.
- `ram_a_o` out 32: RAM byte address (registered).
- `ram_wr_o` out 1: RAM write strobe (registered).
- `ram_dout_o` out 8: RAM write byte (registered).
- `ram_din_i` in 8: RAM read byte. Carries the byte addressed by the `ram_a_o` value that was loaded two edges earlier.

## Operation
- States:
  - `IDLE`
  - `READ` (owner IF or MEM)
  - `WRITE` (MEM only)
  - `DONE`
- Counters:
  - `issue_idx` [2:0] counts addresses issued.
  - `cap_idx` [2:0] counts bytes captured.
  - `n` is the byte count: 1, 2, or 4 from `mem_sel_i`; fetch is always 4.
- IDLE:
  - If `mem_req_i`, start a MEM transaction; else if `if_req_i`, start an IF transaction.
  - MEM wins ties.
  - Request address, data, sel and we are latched at start; later input changes are ignored.
- `mem_sel_i == MEM_NOP` with `mem_req_i`: go straight to DONE with no RAM access; `mem_rdata_o = 0`.
- READ:
  - Issue `ram_a_o = addr + issue_idx` for issue_idx = 0..n-1 on consecutive edges.
  - Capture `ram_din_i` into byte `cap_idx` starting 2 edges after the first issue.
  - After the last capture, go to DONE.
  - Once all addresses are issued, `ram_a_o` returns to 0.
- WRITE:
  - On consecutive edges drive `ram_a_o = addr+i`, `ram_dout_o = wdata[8i+7:8i]`, `ram_wr_o = 1` for i = 0..n-1.
  - Then drive `ram_wr_o = 0`, `ram_a_o = 0`, and go to DONE.
- DONE:
  - The done pulse for the owner is high for exactly this cycle.
  - `*_data_o` holds the assembled bytes; unread upper bytes are 0.
  - Next edge → IDLE.
  - Requests are not sampled in DONE. A requester still asserting req in the first IDLE cycle starts a new transaction, so the requester must drop req when it sees done.
- Address arithmetic is 32-bit modulo: addr+i wraps 0xFFFFFFFF → 0x0.
- IF abort:
  - If `if_req_i` is low at any edge during an IF-owned READ, the FSM goes to IDLE with `ram_a_o = 0` and no `if_done_o`.
  - MEM transactions are never aborted except by `rst`.
- Pending MEM requests wait for an in-flight IF read to complete. No preemption.
- Outside READ/WRITE, `ram_a_o` is 0. Address 0x30000+ is IO with read side effects, so it is never touched speculatively.

## Timing
- Reset values (at the `rst` edge, mid-transaction included):
  - state IDLE.
  - `ram_a_o`=0, `ram_wr_o`=0, `ram_dout_o`=0.
  - `if_done_o`=0, `mem_done_o`=0.
  - `if_data_o`=0, `mem_rdata_o`=0.
  - Counters 0.
- Edge E0 = the IDLE edge that accepts the request.
- Read latency: the done pulse is visible after edge E(n+1).
  - Byte: done after E2.
  - Half: done after E3.
  - Word: done after E5.
- Write latency: `ram_wr_o` is high in the n cycles after E0..E(n-1); done after E(n).
  - Byte: done after E1.
  - Word: done after E4.
- Back-to-back throughput: one IDLE cycle and one DONE cycle between transactions.

## Configuration
- `MEM_CTRL_IF_PRIORITY_EN`:
  - Defined: IF wins IDLE ties.
  - Undefined (default): MEM wins ties.
- All other behaviour is identical in both cases.

## Test plan
- Word load:
  - Stimulus: RAM[0x100..0x103] = 78,56,34,12; `mem_req_i`, sel WORD, addr 0x100.
  - Required: `mem_done_o` one cycle after E5; `mem_rdata_o` = 0x12345678; `ram_a_o` sequence 0x100..0x103 then 0.
- Half store:
  - Stimulus: addr 0x200, wdata 0xAABBCCDD.
  - Required: writes DD@0x200, CC@0x201; no third write; done after E2.
- Tie:
  - Stimulus: `if_req_i` and `mem_req_i` both high in IDLE (macro off).
  - Required: MEM served first; IF done after MEM done + IDLE + 6.
  - With the macro defined, the order is reversed.
- IF abort:
  - Stimulus: drop `if_req_i` after E2 of a fetch at 0x0.
  - Required: no `if_done_o`; `ram_a_o`=0 next cycle; a queued `mem_req_i` starts on the following IDLE edge.
- Reset mid-write:
  - Stimulus: `rst` at E1 of a word store.
  - Required: `ram_wr_o`=0 and `ram_a_o`=0 after that edge; no done pulse; only byte 0 written.
- Wrap and NOP:
  - Stimulus A: half load at 0xFFFFFFFF.
  - Required A: addresses 0xFFFFFFFF, 0x0.
  - Stimulus B: sel NOP.
  - Required B: done one edge after acceptance, rdata 0, `ram_wr_o` never high.
